replay_fifo: RTL and testbench
==============================

REPLAY_FIFO -- requirements
Module: replay_fifo

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WIDTH, 8, data word width in bits (1..32).
- AW, 4, address width; DEPTH = 2**AW words.
- EDGE_WR, 1, 1: wr_next is asynchronous (switch/GPIO), 2-flop synchronised and rising-edge detected; 0: wr_next is a synchronous one-cycle pulse.
- EDGE_RD, 0, same choice for rd_next.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high.
- data_in, input, WIDTH, write data.
- wr_next, input, 1, write strobe.
- data_out, output, WIDTH, word at read pointer (first-word-fall-through).
- rd_next, input, 1, read-advance strobe from the tag core.
- start, input, 1, one-cycle pulse; rewinds the read pointer to the packet mark.
- repeat_en, input, 1, level; 1 = replay mode, reads do not free space.
- clr_flags, input, 1, one-cycle pulse; clears the sticky flags.
- empty, output, 1, no unread word.
- full, output, 1, occupancy == DEPTH.
- overflow, output, 1, sticky; write attempted while full.
- underflow, output, 1, sticky; read attempted while empty.
- level, output, AW+1, occupancy = write_addr - current_addr.
- write_addr, output, AW, write pointer.
- read_addr, output, AW, read pointer.
- current_addr, output, AW, packet mark (oldest retained word).

Function
REQ-003 Internal strobes: wr_stb = edge(wr_next) if EDGE_WR, else wr_next; rd_stb is derived from rd_next the same way using EDGE_RD. Edge path latency SHALL be 3 cycles (2 sync flops + 1 edge flop).
REQ-004 Pointers SHALL be AW+1 bits internally, with MSB wrap bits; ports expose the low AW bits. All pointer arithmetic SHALL be modulo 2**(AW+1).
REQ-005 full = (wr_ptr - mark_ptr == DEPTH); empty = (rd_ptr == wr_ptr); level = wr_ptr - mark_ptr. All three SHALL be combinational from registered pointers.
REQ-006 A write SHALL store data_in at write_addr and increment wr_ptr when wr_stb && !full. A write with wr_stb && full SHALL be dropped and set overflow.
REQ-007 A read SHALL increment rd_ptr when rd_stb && !empty && !start. A read with rd_stb && empty && !start SHALL set underflow and leave the pointers unchanged.
REQ-008 On start, rd_ptr SHALL be set to mark_ptr on the next edge. start SHALL take priority over a simultaneous rd_stb, and the read SHALL be discarded without flagging.
REQ-009 When repeat_en=0, mark_ptr SHALL equal the rd_ptr value after each update, so reads consume data. When repeat_en=1, mark_ptr SHALL hold, retaining all words since the mark for replay.
REQ-010 A repeat_en 1->0 transition SHALL release retained space in the same cycle: mark_ptr <= rd_ptr.
REQ-011 A simultaneous write and read SHALL both occur when neither is blocked. Empty/full SHALL be evaluated on pre-edge pointers, so a write into an empty FIFO does not allow a same-cycle read.
REQ-012 data_out SHALL equal mem[read_addr] combinationally. Memory contents SHALL be undefined until written.
REQ-013 clr_flags SHALL clear overflow and underflow. A flag-setting event in the same cycle SHALL win.

Reset
REQ-014 While reset=1 at an edge:
- wr_ptr, rd_ptr, mark_ptr SHALL be 0.
- overflow and underflow SHALL be 0.
- Synchroniser and edge flops SHALL be 0.
- Resulting outputs: empty=1, full=0, level=0, write_addr=read_addr=current_addr=0.
REQ-015 Reset SHALL override all concurrent strobes. Reset mid-packet SHALL discard all stored data logically; memory is not cleared.

Structure
REQ-016 Default WIDTH/AW values and the flag bit encoding SHALL live in the shared include rfid_fifo_defs.vh.
REQ-017 Synchronise-and-edge-detect SHALL be one sub-module, strobe_sync, instantiated twice and bypassed by generate when its EDGE_* parameter = 0.
REQ-018 Storage SHALL be a plain reg array inferable as distributed RAM. There SHALL be no latches and no second clock.

Verification
REQ-019 Bench scenarios, stimulus -> required response (AW=4, WIDTH=8, EDGE_RD=0):
- Write 0x11..0x1F (15 words), then 1 more -> full=1, level=16. A 17th write -> dropped, overflow=1. clr_flags -> overflow=0.
- repeat_en=0: write 3 words; 3 rd_stb pulses -> data_out steps 0x11, 0x12, 0x13; empty=1, current_addr=read_addr=3. A 4th rd_stb -> underflow=1.
- repeat_en=1: write 0xA0, 0xA1, 0xA2; read all 3; start -> read_addr=0, data_out=0xA0, level=3. Clear repeat_en -> level=0.
- Wrap: 20 write/read pairs in repeat_en=0 -> write_addr=4, never full, data order preserved.
- start and rd_stb in the same cycle -> read_addr = current_addr, underflow=0. Reset asserted mid-stream -> next cycle empty=1, all addresses 0.
- EDGE_WR=1: wr_next held high for 10 cycles -> exactly one write, appearing 3 cycles after the rise.

Source files
------------

// File: rtl/replay_fifo_pkg.sv
// Shared defaults and flag encoding for the replay FIFO.
package replay_fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefAw    = 4;

  // Sticky error flags
  typedef struct packed {
    logic overflow;
    logic underflow;
  } flags_t;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous level strobe.
module strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic stb
);

  logic sync1_q, sync2_q, edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sig;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // One-cycle pulse; the consuming logic acts on the third edge after the rise
  assign stb = sync2_q & ~edge_q;

endmodule

// File: rtl/replay_fifo.sv
// FWFT FIFO with a packet mark: in repeat mode reads leave data retained for replay via start.
module replay_fifo
  import replay_fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned EDGE_WR = 1,
  parameter int unsigned EDGE_RD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_next,
  output logic [WIDTH-1:0] data_out,
  input  logic             rd_next,
  input  logic             start,
  input  logic             repeat_en,
  input  logic             clr_flags,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [AW:0]      level,
  output logic [AW-1:0]    write_addr,
  output logic [AW-1:0]    read_addr,
  output logic [AW-1:0]    current_addr
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic wr_stb, rd_stb;

  if (EDGE_WR != 0) begin : g_wr_sync
    strobe_sync u_wr_sync (.clk(clk), .reset(reset), .sig(wr_next), .stb(wr_stb));
  end else begin : g_wr_bypass
    assign wr_stb = wr_next;
  end

  if (EDGE_RD != 0) begin : g_rd_sync
    strobe_sync u_rd_sync (.clk(clk), .reset(reset), .sig(rd_next), .stb(rd_stb));
  end else begin : g_rd_bypass
    assign rd_stb = rd_next;
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] mark_ptr_q, mark_ptr_d;
  flags_t      flags_q, flags_d;
  logic        do_wr, do_rd;

  assign level        = wr_ptr_q - mark_ptr_q;
  assign full         = (level == DepthW);
  assign empty        = (rd_ptr_q == wr_ptr_q);
  assign write_addr   = wr_ptr_q[AW-1:0];
  assign read_addr    = rd_ptr_q[AW-1:0];
  assign current_addr = mark_ptr_q[AW-1:0];
  assign data_out     = mem[rd_ptr_q[AW-1:0]];
  assign overflow     = flags_q.overflow;
  assign underflow    = flags_q.underflow;

  always_comb begin
    do_wr      = wr_stb & ~full;
    do_rd      = rd_stb & ~empty & ~start;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d   = start ? mark_ptr_q : rd_ptr_q + (AW+1)'(do_rd);
    // Outside repeat mode the mark follows the reader, which also releases space on 1->0
    mark_ptr_d = repeat_en ? mark_ptr_q : rd_ptr_d;
    flags_d.overflow  = (flags_q.overflow & ~clr_flags) | (wr_stb & full);
    flags_d.underflow = (flags_q.underflow & ~clr_flags) | (rd_stb & empty & ~start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mark_ptr_q <= '0;
      flags_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mark_ptr_q <= mark_ptr_d;
      flags_q    <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_replay_fifo.sv
// Randomised and directed bench for replay_fifo against a queue-based reference model.
module tb_replay_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_next = 1'b0, rd_next = 1'b0, start = 1'b0, repeat_en = 1'b0, clr_flags = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, overflow, underflow;
  logic [4:0] level;
  logic [3:0] write_addr, read_addr, current_addr;

  // Second instance exercising the synchronised write strobe
  logic       e_wr = 1'b0;
  logic [7:0] e_din = '0;
  logic [7:0] e_dout;
  logic       e_empty, e_full, e_ovf, e_unf;
  logic [4:0] e_level;
  logic [3:0] e_waddr, e_raddr, e_caddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  replay_fifo #(.WIDTH(8), .AW(4), .EDGE_WR(0), .EDGE_RD(0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_next(wr_next), .data_out(data_out),
    .rd_next(rd_next), .start(start), .repeat_en(repeat_en), .clr_flags(clr_flags),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow), .level(level),
    .write_addr(write_addr), .read_addr(read_addr), .current_addr(current_addr)
  );

  replay_fifo #(.WIDTH(8), .AW(4), .EDGE_WR(1), .EDGE_RD(0)) e_dut (
    .clk(clk), .reset(reset), .data_in(e_din), .wr_next(e_wr), .data_out(e_dout),
    .rd_next(1'b0), .start(1'b0), .repeat_en(1'b0), .clr_flags(1'b0),
    .empty(e_empty), .full(e_full), .overflow(e_ovf), .underflow(e_unf), .level(e_level),
    .write_addr(e_waddr), .read_addr(e_raddr), .current_addr(e_caddr)
  );

  // Reference: queue of words retained since the mark, reader offset into it
  logic [7:0] mq[$];
  int         base = 0;
  int         rd_off = 0;
  bit         m_ovf = 0, m_unf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit s,
                            input bit rp, input bit c, input bit rs);
    bit full0, empty0;
    if (rs) begin
      mq.delete();
      base = 0; rd_off = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full0  = (mq.size() == 16);
      empty0 = (rd_off == mq.size());
      m_ovf  = (m_ovf && !c) || (w && full0);
      m_unf  = (m_unf && !c) || (r && empty0 && !s);
      if (s) rd_off = 0;
      else if (r && !empty0) rd_off++;
      if (w && !full0) mq.push_back(d);
      if (!rp) begin
        repeat (rd_off) void'(mq.pop_front());
        base += rd_off;
        rd_off = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit m_empty;
    m_empty = (rd_off == mq.size());
    check("empty", 32'(empty), 32'(m_empty));
    check("full", 32'(full), 32'(mq.size() == 16));
    check("level", 32'(level), 32'(mq.size()));
    check("write_addr", 32'(write_addr), 32'((base + mq.size()) % 16));
    check("read_addr", 32'(read_addr), 32'((base + rd_off) % 16));
    check("current_addr", 32'(current_addr), 32'(base % 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    if (!m_empty) check("data_out", 32'(data_out), 32'(mq[rd_off]));
  endtask

  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit s,
                       input bit rp, input bit c, input bit rs);
    wr_next = w; data_in = d; rd_next = r; start = s;
    repeat_en = rp; clr_flags = c; reset = rs;
    @(posedge clk);
    model_step(w, d, r, s, rp, c, rs);
    #1;
    compare_all();
  endtask

  initial begin
    bit rp;
    int e_writes;
    logic [3:0] e_prev;

    // Reset state
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_addrs", {20'd0, write_addr, read_addr, current_addr}, 32'd0);

    // Fill to full, overflow, clear
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0, 0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    cycle(1, 8'hEE, 0, 0, 0, 0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    cycle(0, 8'h00, 0, 0, 0, 1, 0);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Consuming reads and underflow
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("rd_seq", 32'(data_out), 32'(8'h11 + i));
      cycle(0, 8'h00, 1, 0, 0, 0, 0);
    end
    check("rd_empty", 32'(empty), 32'd1);
    check("rd_cur", 32'(current_addr), 32'd3);
    check("rd_raddr", 32'(read_addr), 32'd3);
    cycle(0, 8'h00, 1, 0, 0, 0, 0);
    check("unf_set", 32'(underflow), 32'd1);

    // Replay then release
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'hA0 + i), 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 1, 1, 0, 0);
    check("replay_raddr", 32'(read_addr), 32'd0);
    check("replay_data", 32'(data_out), 32'hA0);
    check("replay_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0);
    check("release_level", 32'(level), 32'd0);

    // Wrap with write/read pairs
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'(8'h30 + i), 0, 0, 0, 0, 0);
      check("wrap_data", 32'(data_out), 32'(8'h30 + i));
      cycle(0, 8'h00, 1, 0, 0, 0, 0);
    end
    check("wrap_waddr", 32'(write_addr), 32'd4);

    // start beats a simultaneous read; reset mid-stream
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    cycle(1, 8'h51, 0, 0, 1, 0, 0);
    cycle(1, 8'h52, 0, 0, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 1, 0, 0);
    cycle(0, 8'h00, 1, 1, 1, 0, 0);
    check("start_raddr", 32'(read_addr), 32'(current_addr));
    check("start_unf", 32'(underflow), 32'd0);
    cycle(1, 8'h53, 1, 1, 1, 1, 1);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_addrs", {20'd0, write_addr, read_addr, current_addr}, 32'd0);

    // Random traffic
    rp = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rp = ~rp;
      cycle(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), rp, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 149) == 0));
    end

    // Synchronised write strobe: level held for 10 cycles gives one write on edge 3
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 0, 0);
    e_din = 8'h5A;
    e_wr = 1'b1;
    e_writes = 0;
    e_prev = e_waddr;
    for (int k = 1; k <= 14; k++) begin
      if (k == 11) e_wr = 1'b0;
      @(posedge clk); #1;
      check("edge_waddr", 32'(e_waddr), (k >= 3) ? 32'd1 : 32'd0);
      if (e_waddr != e_prev) e_writes++;
      e_prev = e_waddr;
    end
    check("edge_count", 32'(e_writes), 32'd1);
    check("edge_level", 32'(e_level), 32'd1);
    check("edge_data", 32'(e_dout), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
